// File: rtl/tpu_job_seq.sv
// Job sequencer: copies A/B from memory into the TPU over MMIO, starts it, polls for done and copies C back.
// Optional poll timeout is compiled in with TPU_JOB_SEQ_TIMEOUT_EN.
module tpu_job_seq #(
  parameter int          N          = 4,
  parameter logic [15:0] TPU_BASE   = 16'h0000,
  parameter int          POLL_GAP   = 4,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_src,
  input  logic [15:0] job_dst,
  output logic        mem_rd_en,
  output logic [15:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_en,
  output logic [15:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        mmio_wr,
  output logic        mmio_rd,
  output logic [15:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  output logic [3:0]  mmio_wstrb,
  input  logic [31:0] mmio_rdata,
  input  logic        mmio_ready,
  output logic        busy,
  output logic        irq,
  input  logic        irq_clr,
  output logic        err,
  output logic [15:0] jobs_done
);

  localparam int          NN          = N * N;
  localparam logic [15:0] CTRL_ADDR   = TPU_BASE + 16'h0008;
  localparam logic [15:0] STATUS_ADDR = TPU_BASE + 16'h000C;
  localparam logic [15:0] A_BASE      = TPU_BASE + 16'h0100;
  localparam logic [15:0] B_BASE      = TPU_BASE + 16'h0200;
  localparam logic [15:0] C_BASE      = TPU_BASE + 16'h0300;
  localparam logic [15:0] NN16        = 16'(NN);
  localparam logic [15:0] AB_COUNT    = 16'(2 * NN);
  localparam logic [15:0] AB_LAST     = 16'(2 * NN - 1);
  localparam logic [15:0] C_LAST      = 16'(NN - 1);
  localparam logic [15:0] GAP16       = 16'((POLL_GAP < 1) ? 1 : POLL_GAP);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_KICK   = 3'd2;
  localparam logic [2:0] S_POLL   = 3'd3;
  localparam logic [2:0] S_CLEAR  = 3'd4;
  localparam logic [2:0] S_UNLOAD = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;

  logic [2:0]  state;
  logic [15:0] src, dst;
  logic [15:0] rd_idx, wr_idx, c_idx, poll_wait;
  logic        wr_pend, hold_valid;
  logic [31:0] hold_data;
  logic        load_stall;

`ifdef TPU_JOB_SEQ_TIMEOUT_EN
  localparam logic [31:0] POLL_LAST = 32'((POLL_LIMIT < 1) ? 0 : POLL_LIMIT - 1);
  logic [31:0] poll_cnt;
`endif

  // Outputs decode from state so reset and IDLE/FIN force every strobe, address and data to 0.
  // NOTE: every output gets a default before the case, otherwise unassigned paths infer latches.
  always_comb begin
    job_ready   = (state == S_IDLE);
    busy        = (state != S_IDLE);
    load_stall  = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = 16'h0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = 16'h0;
    mem_wr_data = 32'h0;
    mmio_wr     = 1'b0;
    mmio_rd     = 1'b0;
    mmio_addr   = 16'h0;
    mmio_wdata  = 32'h0;
    mmio_wstrb  = 4'h0;
    case (state)
      S_LOAD: begin
        // Write of element e overlaps the read of e+1; a stalled write freezes the read stream.
        load_stall  = wr_pend && !mmio_ready;
        mem_rd_en   = (rd_idx < AB_COUNT) && !load_stall;
        mem_rd_addr = src + rd_idx;
        if (wr_pend) begin
          mmio_wr    = 1'b1;
          mmio_addr  = (wr_idx < NN16) ? A_BASE + wr_idx : B_BASE + (wr_idx - NN16);
          mmio_wdata = hold_valid ? hold_data : mem_rd_data;
          mmio_wstrb = 4'hF;
        end
      end
      S_KICK, S_CLEAR: begin
        mmio_wr    = 1'b1;
        mmio_addr  = CTRL_ADDR;
        mmio_wdata = (state == S_KICK) ? 32'h1 : 32'h2;
        mmio_wstrb = 4'hF;
      end
      S_POLL: begin
        mmio_rd   = (poll_wait == 16'h0);
        mmio_addr = mmio_rd ? STATUS_ADDR : 16'h0;
      end
      S_UNLOAD: begin
        mmio_rd     = 1'b1;
        mmio_addr   = C_BASE + c_idx;
        mem_wr_en   = mmio_ready;
        mem_wr_addr = dst + c_idx;
        mem_wr_data = mmio_rdata;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      src        <= 16'h0;
      dst        <= 16'h0;
      rd_idx     <= 16'h0;
      wr_idx     <= 16'h0;
      c_idx      <= 16'h0;
      poll_wait  <= 16'h0;
      wr_pend    <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= 32'h0;
      irq        <= 1'b0;
      err        <= 1'b0;
      jobs_done  <= 16'h0;
`ifdef TPU_JOB_SEQ_TIMEOUT_EN
      poll_cnt   <= 32'h0;
`endif
    end else begin
      if (irq_clr) irq <= 1'b0;
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            src        <= job_src;
            dst        <= job_dst;
            rd_idx     <= 16'h0;
            wr_idx     <= 16'h0;
            wr_pend    <= 1'b0;
            hold_valid <= 1'b0;
            err        <= 1'b0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (mem_rd_en) rd_idx <= rd_idx + 16'h1;
          if (load_stall) begin
            // Read data is not guaranteed to persist, so keep the stalled word locally.
            hold_valid <= 1'b1;
            hold_data  <= mmio_wdata;
          end else begin
            hold_valid <= 1'b0;
            wr_pend    <= mem_rd_en;
            if (wr_pend) begin
              wr_idx <= wr_idx + 16'h1;
              if (wr_idx == AB_LAST) state <= S_KICK;
            end
          end
        end
        S_KICK: begin
          if (mmio_ready) begin
            poll_wait <= 16'h0;
`ifdef TPU_JOB_SEQ_TIMEOUT_EN
            poll_cnt  <= 32'h0;
`endif
            state     <= S_POLL;
          end
        end
        S_POLL: begin
          if (poll_wait != 16'h0) begin
            poll_wait <= poll_wait - 16'h1;
          end else if (mmio_ready) begin
            if (mmio_rdata[1]) begin
              state <= S_CLEAR;
`ifdef TPU_JOB_SEQ_TIMEOUT_EN
            end else if (poll_cnt == POLL_LAST) begin
              err   <= 1'b1;
              state <= S_FIN;
            end else begin
              poll_cnt  <= poll_cnt + 32'h1;
              poll_wait <= GAP16;
            end
`else
            end else begin
              poll_wait <= GAP16;
            end
`endif
          end
        end
        S_CLEAR: begin
          if (mmio_ready) begin
            c_idx <= 16'h0;
            state <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          if (mmio_ready) begin
            c_idx <= c_idx + 16'h1;
            if (c_idx == C_LAST) state <= S_FIN;
          end
        end
        S_FIN: begin
          irq       <= 1'b1;
          jobs_done <= jobs_done + 16'h1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_job_seq.sv
// Directed bench for tpu_job_seq: memory and TPU register models, bus monitor, hand-timed checks.
// Define TPU_JOB_SEQ_TIMEOUT_EN to also exercise the poll timeout with POLL_LIMIT=4.
module tb_tpu_job_seq;

  localparam int N  = 4;
  localparam int NN = N * N;
`ifdef TPU_JOB_SEQ_TIMEOUT_EN
  localparam int POLL_LIMIT = 4;
`else
  localparam int POLL_LIMIT = 1024;
`endif
  localparam logic [15:0] CTRL   = 16'h0008;
  localparam logic [15:0] STATUS = 16'h000C;
  localparam logic [15:0] A_B    = 16'h0100;
  localparam logic [15:0] B_B    = 16'h0200;
  localparam logic [15:0] C_B    = 16'h0300;

  logic        clk = 1'b0;
  logic        rst, job_valid, job_ready;
  logic [15:0] job_src, job_dst;
  logic        mem_rd_en, mem_wr_en;
  logic [15:0] mem_rd_addr, mem_wr_addr;
  logic [31:0] mem_rd_data, mem_wr_data;
  logic        mmio_wr, mmio_rd, mmio_ready;
  logic [15:0] mmio_addr;
  logic [31:0] mmio_wdata, mmio_rdata;
  logic [3:0]  mmio_wstrb;
  logic        busy, irq, irq_clr, err;
  logic [15:0] jobs_done;

  always #5 clk = ~clk;

  tpu_job_seq #(.N(N), .TPU_BASE(16'h0000), .POLL_GAP(4), .POLL_LIMIT(POLL_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_src(job_src), .job_dst(job_dst),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_wstrb(mmio_wstrb), .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready),
    .busy(busy), .irq(irq), .irq_clr(irq_clr), .err(err), .jobs_done(jobs_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory image: 0x10..0x2F = 1..32, 0x40..0x5F = 100..131, rest 0.
  function automatic logic [31:0] img(input int a);
    if (a >= 'h10 && a < 'h30) return 32'(a - 'h0F);
    if (a >= 'h40 && a < 'h60) return 32'(100 + a - 'h40);
    return 32'h0;
  endfunction

  function automatic logic [31:0] c_val(input int k);
    return 32'hC0DE_0000 + 32'(k * 17);
  endfunction

  logic [31:0] mem [0:255];
  logic        load_img;
  always @(posedge clk) begin
    if (load_img) for (int i = 0; i < 256; i++) mem[i] <= img(i);
    else if (mem_wr_en) mem[mem_wr_addr[7:0]] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[7:0]];
  end

  // TPU model: STATUS reports done once done_on-1 polls of the current job have completed.
  int polls = 0;
  int poll_base, done_on;
  always @(posedge clk)
    if (mmio_rd && mmio_ready && mmio_addr == STATUS) polls <= polls + 1;

  always_comb begin
    mmio_rdata = 32'h0;
    if (mmio_rd) begin
      if (mmio_addr == STATUS)
        mmio_rdata = (done_on != 0 && polls - poll_base >= done_on - 1) ? 32'h2 : 32'h1;
      else if (mmio_addr >= C_B && mmio_addr < C_B + 16'(NN))
        mmio_rdata = c_val(int'(mmio_addr - C_B));
    end
  end

  function automatic bit is_ab(input logic [15:0] a);
    return (a >= A_B && a < A_B + 16'(NN)) || (a >= B_B && a < B_B + 16'(NN));
  endfunction

  function automatic int ab_index(input logic [15:0] a);
    return (a >= B_B) ? NN + int'(a - B_B) : int'(a - A_B);
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_ab = 0, n_ctrl = 0, n_poll = 0, n_c = 0, n_mw = 0, n_traffic = 0, n_acc = 0, n_e5 = 0;
  int order_err = 0, excl_err = 0, idle_err = 0, ab_exp = 0, acc_cyc = 0;
  logic [31:0] ab_val   [0:2*NN-1];
  logic [31:0] ctrl_log [0:255];
  int          ctrl_cyc [0:255];
  int          poll_cyc [0:255];

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mmio_wr && mmio_rd) excl_err <= excl_err + 1;
    if (job_ready && (mmio_wr || mmio_rd || mem_rd_en || mem_wr_en)) idle_err <= idle_err + 1;
    if (mmio_wr || mmio_rd || mem_rd_en || mem_wr_en) n_traffic <= n_traffic + 1;
    if (job_valid && job_ready) begin
      n_acc   <= n_acc + 1;
      ab_exp  <= 0;
      acc_cyc <= cyc;
    end
    if (mmio_wr && mmio_addr == A_B + 16'd5) n_e5 <= n_e5 + 1;
    if (mmio_wr && mmio_ready && is_ab(mmio_addr)) begin
      if (ab_index(mmio_addr) != ab_exp) order_err <= order_err + 1;
      ab_val[ab_index(mmio_addr)] <= mmio_wdata;
      ab_exp <= ab_exp + 1;
      n_ab   <= n_ab + 1;
    end
    if (mmio_wr && mmio_ready && mmio_addr == CTRL) begin
      ctrl_log[n_ctrl % 256] <= mmio_wdata;
      ctrl_cyc[n_ctrl % 256] <= cyc;
      n_ctrl <= n_ctrl + 1;
    end
    if (mmio_rd && mmio_ready && mmio_addr == STATUS) begin
      poll_cyc[n_poll % 256] <= cyc;
      n_poll <= n_poll + 1;
    end
    if (mmio_rd && mmio_ready && mmio_addr >= C_B && mmio_addr < C_B + 16'(NN)) n_c <= n_c + 1;
    if (mem_wr_en) n_mw <= n_mw + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] s, input logic [15:0] d);
    job_valid = 1'b1;
    job_src   = s;
    job_dst   = d;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_finish"}, 32'(busy), 32'h0);
  endtask

  task automatic pulse_irq_clr();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, 32'({busy, irq, err, mmio_wr, mmio_rd, mem_rd_en, mem_wr_en}), 32'h0);
    check({tag, "_jobs_done"}, 32'(jobs_done), 32'h0);
    check({tag, "_addr"}, 32'(mem_rd_addr | mem_wr_addr | mmio_addr), 32'h0);
    check({tag, "_data"}, mem_wr_data | mmio_wdata | 32'(mmio_wstrb), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int ab0, k0, p0, c0, mw0, e50, acc0, tr0;

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_src = 16'h0; job_dst = 16'h0;
    mmio_ready = 1'b1; irq_clr = 1'b0; load_img = 1'b1; poll_base = 0; done_on = 3;

    // Reset state
    @(negedge clk);
    check_all_zero("rst");
    tick();
    load_img = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(job_ready), 32'h1);
    tick();

    // Nominal job: src 0x10, dst 0x80, done on 3rd poll
    poll_base = polls; done_on = 3;
    ab0 = n_ab; k0 = n_ctrl; p0 = n_poll; c0 = n_c; mw0 = n_mw;
    start_job(16'h0010, 16'h0080);
    wait_idle("t1");
    check("t1_ab_count", 32'(n_ab - ab0), 32'd32);
    check("t1_a0", ab_val[0], 32'd1);
    check("t1_b0", ab_val[16], 32'd17);
    check("t1_b15", ab_val[31], 32'd32);
    check("t1_ctrl_count", 32'(n_ctrl - k0), 32'd2);
    check("t1_ctrl_start", ctrl_log[k0 % 256], 32'h1);
    check("t1_ctrl_clear", ctrl_log[(k0 + 1) % 256], 32'h2);
    check("t1_kick_cycle", 32'(ctrl_cyc[k0 % 256] - acc_cyc), 32'd34);
    check("t1_poll_count", 32'(n_poll - p0), 32'd3);
    check("t1_poll1_cycle", 32'(poll_cyc[p0 % 256] - acc_cyc), 32'd35);
    check("t1_poll_gap1", 32'(poll_cyc[(p0 + 1) % 256] - poll_cyc[p0 % 256]), 32'd5);
    check("t1_poll_gap2", 32'(poll_cyc[(p0 + 2) % 256] - poll_cyc[(p0 + 1) % 256]), 32'd5);
    check("t1_clear_cycle", 32'(ctrl_cyc[(k0 + 1) % 256] - acc_cyc), 32'd46);
    check("t1_c_reads", 32'(n_c - c0), 32'd16);
    check("t1_mem_writes", 32'(n_mw - mw0), 32'd16);
    for (int k = 0; k < NN; k++) check($sformatf("t1_c%0d", k), mem[8'h80 + k], c_val(k));
    check("t1_irq", 32'(irq), 32'h1);
    check("t1_jobs_done", 32'(jobs_done), 32'd1);
    check("t1_err", 32'(err), 32'h0);

    // Stall on LOAD element 5 for 3 cycles
    pulse_irq_clr();
    check("t2_irq_cleared", 32'(irq), 32'h0);
    poll_base = polls;
    ab0 = n_ab; e50 = n_e5;
    start_job(16'h0040, 16'h0090);
    repeat (6) tick();
    mmio_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("t2_stall_rd_en", 32'(mem_rd_en), 32'h0);
      check("t2_stall_rd_addr", 32'(mem_rd_addr), 32'h46);
      tick();
    end
    mmio_ready = 1'b1;
    wait_idle("t2");
    check("t2_e5_seen", 32'(n_e5 - e50), 32'd4);
    check("t2_ab_count", 32'(n_ab - ab0), 32'd32);
    check("t2_order", 32'(order_err), 32'h0);
    for (int i = 0; i < 2 * NN; i++) check($sformatf("t2_ab%0d", i), ab_val[i], img('h40 + i));
    check("t2_c_first", mem[8'h90], c_val(0));
    check("t2_c_last", mem[8'h9F], c_val(15));
    check("t2_jobs_done", 32'(jobs_done), 32'd2);

    // job_valid held while busy
    pulse_irq_clr();
    poll_base = polls;
    acc0 = n_acc;
    start_job(16'h0010, 16'h00A0);
    job_valid = 1'b1; job_src = 16'h0040; job_dst = 16'h00B0;
    repeat (5) tick();
    @(negedge clk);
    check("t3_ready_busy", 32'(job_ready), 32'h0);
    wait_idle("t3a");
    check("t3_acc_while_busy", 32'(n_acc - acc0), 32'd1);
    check("t3_jobs_done_a", 32'(jobs_done), 32'd3);
    check("t3_ready_idle", 32'(job_ready), 32'h1);
    poll_base = polls;
    tick();
    job_valid = 1'b0;
    check("t3_second_busy", 32'(busy), 32'h1);
    wait_idle("t3b");
    check("t3_acc_total", 32'(n_acc - acc0), 32'd2);
    check("t3_jobs_done_b", 32'(jobs_done), 32'd4);
    check("t3_c_a", mem[8'hA5], c_val(5));
    check("t3_c_b", mem[8'hBF], c_val(15));

    // irq_clr coinciding with FIN
    pulse_irq_clr();
    check("t4_irq_pre", 32'(irq), 32'h0);
    poll_base = polls;
    start_job(16'h0010, 16'h00C0);
    repeat (62) tick();
    irq_clr = 1'b1;
    @(negedge clk);
    check("t4_fin_state", 32'({busy, job_ready, mmio_wr, mmio_rd, mem_rd_en, mem_wr_en}), 32'b100000);
    tick();
    irq_clr = 1'b0;
    check("t4_irq_set_wins", 32'(irq), 32'h1);
    check("t4_idle", 32'(busy), 32'h0);
    check("t4_jobs_done", 32'(jobs_done), 32'd5);
    tick();
    pulse_irq_clr();
    check("t4_irq_later_clr", 32'(irq), 32'h0);

    // rst during POLL
    poll_base = polls;
    start_job(16'h0010, 16'h00D0);
    repeat (36) tick();
    check("t5_in_poll", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("t5_rst");
    tr0 = n_traffic;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_after", 32'(job_ready), 32'h1);
    repeat (10) tick();
    check("t5_no_traffic", 32'(n_traffic - tr0), 32'h0);
    check("t5_dropped_dst", mem[8'hD0], 32'h0);
    poll_base = polls;
    c0 = n_c;
    start_job(16'h0010, 16'h00E0);
    wait_idle("t5");
    check("t5_c_reads", 32'(n_c - c0), 32'd16);
    check("t5_c_first", mem[8'hE0], c_val(0));
    check("t5_c_last", mem[8'hEF], c_val(15));
    check("t5_jobs_done", 32'(jobs_done), 32'd1);
    check("t5_irq", 32'(irq), 32'h1);

`ifdef TPU_JOB_SEQ_TIMEOUT_EN
    // Poll timeout with done never reported
    pulse_irq_clr();
    poll_base = polls; done_on = 0;
    p0 = n_poll; c0 = n_c; mw0 = n_mw;
    start_job(16'h0010, 16'h00F0);
    wait_idle("t6");
    check("t6_poll_count", 32'(n_poll - p0), 32'd4);
    check("t6_err", 32'(err), 32'h1);
    check("t6_irq", 32'(irq), 32'h1);
    check("t6_no_c_reads", 32'(n_c - c0), 32'h0);
    check("t6_no_mem_writes", 32'(n_mw - mw0), 32'h0);
    check("t6_jobs_done", 32'(jobs_done), 32'd2);
    poll_base = polls;
    start_job(16'h0010, 16'h00F0);
    check("t6_err_cleared", 32'(err), 32'h0);
    wait_idle("t6b");
    check("t6_err_again", 32'(err), 32'h1);
`else
    check("err_tied_low", 32'(err), 32'h0);
`endif

    check("excl_rd_wr", 32'(excl_err), 32'h0);
    check("idle_strobes", 32'(idle_err), 32'h0);
    check("ab_order", 32'(order_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tpu_job_seq.md
TPU_JOB_SEQ -- requirements
Module: tpu_job_seq

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the matrix dimension; NN=N*N.
REQ-002 The block SHALL have parameter TPU_BASE, default 16'h0000, meaning the TPU register window base.
REQ-003 The block SHALL have parameter POLL_GAP, default 4, meaning idle cycles between STATUS polls (>=1).
REQ-004 The block SHALL have parameter POLL_LIMIT, default 1024, meaning the maximum number of polls when the timeout feature is compiled in.
REQ-005 Port clk  in  1  is the single clock, and port rst  in  1  is the reset; rst SHALL be asynchronous and active-high.
REQ-006 Ports job_valid in 1 / job_ready out 1 SHALL form the job handshake; job_src in 16 is the memory word address of A (B at job_src+NN); job_dst in 16 is the memory word address for C.
REQ-007 Ports mem_rd_en out 1, mem_rd_addr out 16, mem_rd_data in 32 SHALL form the operand memory read port, with data valid one cycle after mem_rd_en.
REQ-008 Ports mem_wr_en out 1, mem_wr_addr out 16, mem_wr_data out 32 SHALL form the result memory write port.
REQ-009 Ports mmio_wr out 1, mmio_rd out 1, mmio_addr out 16, mmio_wdata out 32, mmio_wstrb out 4, mmio_rdata in 32 (combinational), mmio_ready in 1 SHALL form the TPU register master.
REQ-010 Ports busy out 1, irq out 1, irq_clr in 1, err out 1 and jobs_done out 16 SHALL provide status.

Function
REQ-011 TPU map SHALL be: CTRL=TPU_BASE+8 (bit0 start, bit1 clear_done); STATUS=TPU_BASE+C (bit0 busy, bit1 done); A=TPU_BASE+100+k; B=TPU_BASE+200+k; C=TPU_BASE+300+k, with k in 0..NN-1.
REQ-012 The FSM SHALL have states IDLE, LOAD, KICK, POLL, CLEAR, UNLOAD, FIN; job_ready=1 only in IDLE; busy=1 in every state except IDLE.
REQ-013 In IDLE, job_valid&&job_ready SHALL latch src/dst and enter LOAD on the next cycle.
REQ-014 LOAD: element e (0..2NN-1) SHALL be read at mem_rd_addr=src+e in cycle e, and written in cycle e+1 with mmio_wr=1, wdata=mem_rd_data, wstrb=4'hF, address A+e (e<NN) or B+e-NN; LOAD SHALL take 2NN+1 cycles with no stall.
REQ-015 Any MMIO cycle with mmio_ready=0 SHALL be repeated unchanged on the next cycle, and mem read issue SHALL freeze while it is repeated.
REQ-016 KICK SHALL issue one write of 32'h1 to CTRL and then enter POLL.
REQ-017 POLL SHALL issue one STATUS read, then wait POLL_GAP cycles before the next read; when mmio_rdata[1]=1 on a read, the FSM SHALL enter CLEAR.
REQ-018 CLEAR SHALL issue one write of 32'h2 to CTRL and then enter UNLOAD.
REQ-019 UNLOAD: in cycle k the FSM SHALL drive mmio_rd at C+k and, in the same cycle, mem_wr_en=1, mem_wr_addr=dst+k, mem_wr_data=mmio_rdata; UNLOAD SHALL take NN cycles.
REQ-020 FIN SHALL set irq, increment jobs_done (wrapping 16'hFFFF->0) and return to IDLE in one cycle.
REQ-021 irq SHALL stay high until irq_clr; if irq_clr coincides with FIN, irq SHALL end at 1 (set wins).
REQ-022 mmio_wr and mmio_rd SHALL never be high together; all strobes SHALL be 0 in IDLE and FIN.
REQ-023 job_valid SHALL be ignored while busy.

Reset
REQ-024 During rst, state=IDLE and busy, irq, err, jobs_done, mmio_wr, mmio_rd, mem_rd_en and mem_wr_en SHALL be 0, and all address and data outputs SHALL be 0.
REQ-025 rst asserted mid-job SHALL drop the job with no further MMIO or memory traffic; job_ready SHALL be 1 on the first cycle after deassertion.

Configuration
REQ-026 With macro TPU_JOB_SEQ_TIMEOUT_EN defined, POLL SHALL count polls; after POLL_LIMIT polls without done, the FSM SHALL enter FIN with err=1, skipping CLEAR and UNLOAD, and err SHALL clear on the next accepted job.
REQ-027 Without TPU_JOB_SEQ_TIMEOUT_EN, POLL SHALL poll indefinitely and err SHALL be tied to 0.

Verification
REQ-028 With N=4, job src=0x10, dst=0x80, mem[0x10..0x2F]=1..32, and the TPU reporting done on the 3rd poll: the bench SHALL see 32 A/B writes with A+0=1 and B+15=32, then CTRL=1, 3 polls 5 cycles apart, CTRL=2, 16 C reads copied to mem 0x80..0x8F, irq=1 and jobs_done=1.
REQ-029 With mmio_ready held 0 for 3 cycles during LOAD element 5: the bench SHALL see the element-5 write repeated 4 times, mem_rd_addr frozen, and no element skipped or duplicated in memory order.
REQ-030 With job_valid asserted while busy: the bench SHALL see job_ready=0 and the second job accepted only after FIN.
REQ-031 With irq_clr pulsed in the same cycle as FIN: the bench SHALL see irq=1 after that cycle and irq=0 after a later irq_clr.
REQ-032 With rst asserted during POLL: the bench SHALL see all outputs 0 immediately, no further MMIO traffic, and a fresh job completing normally.
REQ-033 With TPU_JOB_SEQ_TIMEOUT_EN defined, POLL_LIMIT=4 and done never asserted: the bench SHALL see exactly 4 polls, err=1, irq=1 and no UNLOAD traffic.
